// File: rtl/axi_pkg.sv
// Shared AXI encodings and FSM state types for the CPU-side memory slave.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_pkg;

  // AxBURST encodings
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // xRESP encodings
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

endpackage

// File: rtl/axi_mem_slave_ram.sv
// Word-addressed storage: one asynchronous read port, one byte-enabled write port.
// Latency: read is combinational, write lands on the next clk edge.
// Backpressure: none; always accepts a write and always presents read data.
//
// Ports: clk; rd_addr/rd_dat (async read); wr_vld/wr_addr/wr_strb/wr_dat (sync write).
// Contents are not reset.
module axi_mem_slave_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int WORD_AW    = 12,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic [WORD_AW-1:0]    rd_addr,
  output logic [DATA_WIDTH-1:0] rd_dat,
  input  logic                  wr_vld,
  input  logic [WORD_AW-1:0]    wr_addr,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic [DATA_WIDTH-1:0] wr_dat
);

  localparam int DEPTH = 1 << WORD_AW;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // A same-cycle read of the word being written sees the old contents.
  assign rd_dat = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_vld) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (wr_strb[i]) begin
          mem[wr_addr][i*8 +: 8] <= wr_dat[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 slave memory (FIXED/INCR bursts, WRAP handled as INCR) for the CPU simulation bus.
// Latency: first R beat one cycle after AR handshake, then back-to-back; B one cycle after last W.
// Backpressure: rready=0 holds the R beat; W stalls until AW accepted; bready=0 holds B.
//
// Ports: clk, resetn (async active-low); AR/R read channels; AW/W/B write channels.
// Read and write FSMs run independently against one shared array; one burst per channel.
module axi_mem_slave
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  // read address
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  // read data
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  // write address
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  // write data
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  // write response
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready
);

  // Next beat address. Anything other than INCR/WRAP (i.e. FIXED) stays put;
  // the add wraps naturally at the top of the ADDR_WIDTH space.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] step;
    step = ADDR_WIDTH'(1) << size;
    if (burst == BURST_INCR || burst == BURST_WRAP) begin
      return addr + step;
    end
    return addr;
  endfunction

  // ---------------------------------------------------------------- read path
  rd_state_t             r_state, r_state_nxt;
  logic                  ar_rdy_q;
  logic [ID_WIDTH-1:0]   r_id_q;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [7:0]            r_len_q;
  logic [7:0]            r_cnt_q;
  logic [2:0]            r_size_q;
  logic [1:0]            r_burst_q;
  logic                  r_vld;
  logic                  r_last;
  logic                  ar_hs;
  logic                  r_hs;

  assign ar_hs  = s_axi_arvalid && ar_rdy_q;
  assign r_last = (r_cnt_q == r_len_q);
  assign r_hs   = r_vld && s_axi_rready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= r_state_nxt;
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    r_vld       = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        r_vld = 1'b1;
        if (s_axi_rready && r_last) begin
          r_state_nxt = R_IDLE;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // arready is a flop so it comes up one edge after reset release and
  // drops the instant reset is asserted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_rdy_q  <= 1'b0;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
    end else begin
      ar_rdy_q <= (r_state_nxt == R_IDLE);
      if (ar_hs) begin
        r_id_q    <= s_axi_arid;
        r_addr_q  <= s_axi_araddr;
        r_len_q   <= s_axi_arlen;
        r_size_q  <= s_axi_arsize;
        r_burst_q <= s_axi_arburst;
        r_cnt_q   <= '0;
      end else if (r_hs && !r_last) begin
        r_cnt_q  <= r_cnt_q + 8'd1;
        r_addr_q <= next_addr(r_addr_q, r_size_q, r_burst_q);
      end
    end
  end

  assign s_axi_arready = ar_rdy_q;
  assign s_axi_rvalid  = r_vld;
  assign s_axi_rlast   = r_vld && r_last;
  assign s_axi_rid     = r_id_q;
  assign s_axi_rresp   = RESP_OKAY;

  // --------------------------------------------------------------- write path
  wr_state_t             w_state, w_state_nxt;
  logic                  aw_rdy_q;
  logic [ID_WIDTH-1:0]   w_id_q;
  logic [ADDR_WIDTH-1:0] w_addr_q;
  logic [7:0]            w_len_q;
  logic [7:0]            w_cnt_q;
  logic [2:0]            w_size_q;
  logic [1:0]            w_burst_q;
  logic                  w_err_q;
  logic                  w_rdy;
  logic                  b_vld;
  logic                  w_last_beat;
  logic                  aw_hs;
  logic                  w_hs;

  assign aw_hs       = s_axi_awvalid && aw_rdy_q;
  assign w_hs        = w_rdy && s_axi_wvalid;
  assign w_last_beat = (w_cnt_q == w_len_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state <= W_IDLE;
    end else begin
      w_state <= w_state_nxt;
    end
  end

  // The burst length comes from awlen alone; a misplaced wlast only flags
  // SLVERR, it never shortens or stretches the burst.
  always_comb begin
    w_state_nxt = w_state;
    w_rdy       = 1'b0;
    b_vld       = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_hs) begin
          w_state_nxt = W_DATA;
        end
      end
      W_DATA: begin
        w_rdy = 1'b1;
        if (s_axi_wvalid && w_last_beat) begin
          w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        b_vld = 1'b1;
        if (s_axi_bready) begin
          w_state_nxt = W_IDLE;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_rdy_q  <= 1'b0;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
    end else begin
      aw_rdy_q <= (w_state_nxt == W_IDLE);
      if (aw_hs) begin
        w_id_q    <= s_axi_awid;
        w_addr_q  <= s_axi_awaddr;
        w_len_q   <= s_axi_awlen;
        w_size_q  <= s_axi_awsize;
        w_burst_q <= s_axi_awburst;
        w_cnt_q   <= '0;
        w_err_q   <= 1'b0;
      end else if (w_hs) begin
        if (s_axi_wlast != w_last_beat) begin
          w_err_q <= 1'b1;
        end
        if (!w_last_beat) begin
          w_cnt_q  <= w_cnt_q + 8'd1;
          w_addr_q <= next_addr(w_addr_q, w_size_q, w_burst_q);
        end
      end
    end
  end

  assign s_axi_awready = aw_rdy_q;
  assign s_axi_wready  = w_rdy;
  assign s_axi_bvalid  = b_vld;
  assign s_axi_bid     = w_id_q;
  assign s_axi_bresp   = b_vld ? (w_err_q ? RESP_SLVERR : RESP_OKAY) : RESP_OKAY;

  // ------------------------------------------------------------------ storage
  axi_mem_slave_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORD_AW    (ADDR_WIDTH - 2),
    .STRB_WIDTH (STRB_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rd_addr (r_addr_q[ADDR_WIDTH-1:2]),
    .rd_dat  (s_axi_rdata),
    .wr_vld  (w_hs),
    .wr_addr (w_addr_q[ADDR_WIDTH-1:2]),
    .wr_strb (s_axi_wstrb),
    .wr_dat  (s_axi_wdata)
  );

endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
- AXI4 slave memory: the responder end of the CPU-side AXI bus that the instruction/data arbiter drives.
- Serves AR/R and AW/W/B with FIXED and INCR bursts from an internal word-addressed RAM.
- Used as the simulation memory behind the custom CPU.
- Read and write paths are independent state machines sharing one storage array.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; fixed at 32 in this block.
- ADDR_WIDTH, 14, byte address width; RAM holds 2^(ADDR_WIDTH-2) words.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.
- ID_WIDTH, 4, transaction ID width.

Ports:
- clk  in  1  clock, all logic on posedge
- resetn  in  1  asynchronous active-low reset
- s_axi_arid  in  ID_WIDTH  read ID
- s_axi_araddr  in  ADDR_WIDTH  read byte address
- s_axi_arlen  in  8  beats-1
- s_axi_arsize  in  3  log2 bytes per beat
- s_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP (treated as INCR)
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
- s_axi_rid  out  ID_WIDTH  echoed arid
- s_axi_rdata  out  DATA_WIDTH  read data
- s_axi_rresp  out  2  always 00
- s_axi_rlast  out  1  final beat
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake
- s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst  in  as AR  write address
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  STRB_WIDTH  byte enables
- s_axi_wlast  in  1  master's last-beat flag
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake
- s_axi_bid  out  ID_WIDTH  echoed awid
- s_axi_bresp  out  2  00 OKAY, 10 SLVERR
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake
- arlock/arcache/arprot/awlock/awcache/awprot are not ports; they are ignored.

Behaviour:
- Reset (async, resetn=0):
  - Both FSMs go to IDLE.
  - arready, awready, rvalid, wready, bvalid, rlast = 0; rid, bid, bresp = 0.
  - RAM contents are not cleared.
- arready/awready are registered: they rise on the first posedge after resetn deasserts, and mid-operation reset drops them at once.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. On arvalid&arready, latch id, addr, len, size, burst; beat counter=0; go to R_DATA with arready=0.
  - R_DATA: rvalid=1, rdata=mem[raddr[ADDR_WIDTH-1:2]] (asynchronous array read), rlast=(cnt==len).
  - On rvalid&rready: if rlast, go to R_IDLE (arready=1 next cycle); else cnt+1 and addr advances.
  - Latency: first beat valid one cycle after the AR handshake. Following beats are back-to-back while rready=1.
  - rready=0 holds rdata, rlast and rid stable.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1, wready=0, so W data sent ahead of AW is stalled, not dropped. On AW handshake, latch fields, cnt=0, err=0.
  - W_DATA: wready=1. On each W handshake, write mem[waddr word] byte lanes where wstrb[i]=1, then advance addr.
  - If wlast != (cnt==len), set err. The burst ends on cnt==len regardless of wlast; then go to W_RESP.
  - W_RESP: bvalid=1, bid=latched id, bresp = err ? 2'b10 : 2'b00. On bready, go to W_IDLE.
- Address advance:
  - INCR/WRAP: addr += (1<<size) in ADDR_WIDTH-bit arithmetic; wraps modulo RAM size.
  - FIXED: addr unchanged.
  - Data is always a full word; narrow writes rely on wstrb and lanes are not shifted.
- Simultaneous read and write of the same word in one cycle: the read returns pre-write data; the write lands at the edge.
- Read and write bursts proceed concurrently with no ordering between channels.
- One outstanding transaction per channel; no interleaving.

Decomposition:
- Shared package axi_pkg:
  - burst encodings (FIXED/INCR/WRAP)
  - resp encodings (OKAY/SLVERR)
  - read and write FSM state enums
- Sub-module axi_mem_slave_ram: 2^(ADDR_WIDTH-2) x DATA_WIDTH array, one async read port, one byte-enabled sync write port.

Test Plan:
- Reset then single write: AW addr=0x10 len=0 INCR, W data=0xDEADBEEF strb=F wlast=1 -> bvalid with bresp=00 and bid=awid; then AR 0x10 len=0 -> rdata=0xDEADBEEF, rlast=1, rvalid 1 cycle after AR handshake.
- INCR burst: write len=3 from 0x100 with data 1,2,3,4, then read back with rready toggling 1,0,1,0 -> beats 1..4 in order, data held while stalled, rlast only on beat 4.
- FIXED burst: write len=2 to 0x20 with data A,B,C -> read of 0x20 returns C; 0x24 unchanged.
- Byte strobe: write 0x11223344 strb=0101 over 0xFFFFFFFF -> readback 0xFF22FF44.
- wlast asserted on beat 2 of len=3 -> all 4 beats still accepted; bresp=10.
- Reset mid-read-burst after beat 1 of len=7 -> rvalid=0 immediately; arready=1 one cycle after resetn rises; previously written data intact.
